fcmp_max_reducer: RTL and testbench
===================================

// Module: fcmp_max_reducer
// PURPOSE
//   Streaming max/argmax reduction over N_ELEMS FloPoCo-format floats (wE=4, wF=4, 11-bit words),
//   built around one fcmplt instance (combinational, unordered + XltY). Sequences comparisons of
//   each accepted input against a running maximum; emits max value, its index and an unordered flag.
//   Sits behind maxpool/relu-reduce loops in generated HLS datapaths; one reduction in flight.
// PARAMETERS
//   WE       4  exponent width (fixed by fcmplt core; informational)
//   WF       4  fraction width (fixed by fcmplt core; informational)
//   N_ELEMS  4  elements per reduction, >=2
//   IDX_W    $clog2(N_ELEMS)  index width (derived, localparam)
// PORTS
//   clk           in   1      clock, rising edge
//   rst_n         in   1      async active-low reset
//   in_valid      in   1      input element valid
//   in_ready      out  1      block can accept element
//   in_data       in   11     FloPoCo word {exc[1:0], sign, exp[3:0], frac[3:0]}
//   out_valid     out  1      result valid
//   out_ready     in   1      consumer accepts result
//   out_max       out  11     maximum element (FloPoCo word)
//   out_idx       out  IDX_W  position (0-based) of out_max in the stream
//   out_unordered out  1      >=1 NaN element seen in this reduction
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, count=0, in_ready=0 while asserted, out_valid=0,
//     out_max=0, out_idx=0, out_unordered=0. Reset mid-reduction discards partial result.
//   - States: IDLE (no element yet) -> ACCUM (>=1 element) -> DONE (result held).
//     in_ready=1 in IDLE/ACCUM, 0 in DONE. Accept = in_valid & in_ready.
//   - IDLE accept: run_max<=in_data, run_idx<=0, nan_seen<=isNaN(in), count<=1, ->ACCUM.
//   - ACCUM accept: fcmplt(X=run_max, Y=in_data). Replace (run_max<=in_data, run_idx<=count)
//     iff XltY=1, or run_max is NaN and in_data is not NaN (see CONFIGURATION). Ties, +0 vs -0
//     (compare equal) keep earlier element. nan_seen |= isNaN(in). count++.
//   - Accept with count==N_ELEMS-1 -> DONE next cycle, out_valid=1 the cycle after last accept
//     (latency 1). out_* registered, stable while out_valid & ~out_ready.
//   - DONE: out_valid & out_ready -> IDLE, out_valid=0, count=0; in_ready=1 from next cycle
//     (no same-cycle accept of next stream's first element).
//   - isNaN: exc==2'b11. count wraps only via DONE->IDLE; never exceeds N_ELEMS-1.
//   - in_valid deasserted mid-stream: hold state indefinitely, no timeout.
// CONFIGURATION
//   FCMP_MAX_NAN_PROPAGATE_EN
//     defined:   first NaN accepted becomes run_max/run_idx and is sticky (no later replacement);
//                out_max is NaN, out_idx=its position, out_unordered=1.
//     undefined: NaN inputs never replace an ordered run_max; a NaN run_max (from element 0) is
//                replaced by the first ordered element; out_max is NaN only if all inputs NaN
//                (then out_idx=0). out_unordered=1 whenever any NaN seen, both modes.
// TESTING
//   Encodings: 1.0=0x270, 2.0=0x280, -1.0=0x370, +inf=0x400, -inf=0x500, +0=0x000, NaN=0x600.
//   1) N=4 stream 0x270,0x280,0x370,0x000 -> out_max=0x280, out_idx=1, unordered=0, 1 cycle after last.
//   2) -inf,-1.0,+inf,2.0 -> out_max=0x400, idx=2; ties 0x270,0x270,0x270,0x270 -> idx=0.
//   3) 0x270,0x600,0x280,0x370: EN undef -> max=0x280,idx=2,unord=1; EN def -> max=0x600,idx=1,unord=1.
//   4) all four 0x600 -> max=0x600, idx=0, unord=1 (both modes).
//   5) out_ready=0 for 5 cycles: out_* stable, in_ready=0; gaps in in_valid don't alter result.
//   6) rst_n low after 2 accepts -> all outputs 0 asynchronously; next 4 elements reduce cleanly.

Source files
------------

// File: rtl/fcmp_max_reducer.sv
// Streaming max/argmax over N_ELEMS FloPoCo floats (wE=4, wF=4) using one fcmplt compare; optional macro FCMP_MAX_NAN_PROPAGATE_EN.
// Latency: result valid the cycle after the last element is accepted; one reduction in flight.
// Backpressure: in_ready drops while a result is held; out_* stay stable until out_ready.

// Combinational FloPoCo less-than: unordered if either operand is NaN, xlty only for ordered pairs.
module fcmplt (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        unordered,
  output logic        xlty
);

  // Map a word onto a signed ordinal: zeros collapse to 0 so +0 and -0 compare equal,
  // infinities sit beyond every normal magnitude.
  function automatic logic signed [11:0] order_key(input logic [10:0] w);
    logic [9:0] mag;
    case (w[10:9])
      2'b00:   mag = 10'd0;
      2'b01:   mag = {2'b00, w[7:0]} + 10'd1;
      default: mag = 10'h3FF;
    endcase
    order_key = w[8] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
  endfunction

  // Ordering decision; suppressed whenever a NaN is involved.
  always_comb begin
    unordered = (&x[10:9]) | (&y[10:9]);
    xlty      = ~unordered & (order_key(x) < order_key(y));
  end

endmodule

module fcmp_max_reducer #(
  parameter int WE      = 4,
  parameter int WF      = 4,
  parameter int N_ELEMS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [10:0]                in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [10:0]                out_max,
  output logic [$clog2(N_ELEMS)-1:0] out_idx,
  output logic                       out_unordered
);

  localparam int IDX_W = $clog2(N_ELEMS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [10:0]        run_max;
  logic [IDX_W-1:0]   run_idx;
  logic [IDX_W-1:0]   count;
  logic               nan_seen;
  logic               accept;
  logic               last;
  logic               in_nan;
  logic               run_nan;
  logic               cmp_unord;
  logic               cmp_lt;
  logic               replace;

  fcmplt u_cmp (
    .x         (run_max),
    .y         (in_data),
    .unordered (cmp_unord),
    .xlty      (cmp_lt)
  );

  // Handshake qualifiers and the replace decision for the running maximum.
  always_comb begin
    in_ready = rst_n & (state != DONE);
    accept   = in_valid & in_ready;
    last     = (count == IDX_W'(N_ELEMS - 1));
    in_nan   = &in_data[10:9];
    run_nan  = &run_max[10:9];
`ifdef FCMP_MAX_NAN_PROPAGATE_EN
    // First NaN wins and then sticks.
    replace  = ~run_nan & (in_nan | cmp_lt);
`else
    // NaNs never displace an ordered maximum; a NaN head yields to the first ordered element.
    replace  = cmp_lt | (run_nan & ~in_nan);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: first element opens the reduction, last one closes it, consumer releases it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = ACCUM;
      ACCUM:   if (accept && last)   state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Running max/argmax, NaN tracking and element count; count holds on the last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max  <= '0;
      run_idx  <= '0;
      nan_seen <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        run_max  <= in_data;
        run_idx  <= '0;
        nan_seen <= in_nan;
        count    <= IDX_W'(1);
      end else begin
        if (replace) begin
          run_max <= in_data;
          run_idx <= count;
        end
        nan_seen <= nan_seen | in_nan;
        if (!last) count <= count + IDX_W'(1);
      end
    end else if (state == DONE && out_ready) begin
      count <= '0;
    end
  end

  // Result is the registered running state, frozen while in DONE.
  always_comb begin
    out_valid     = (state == DONE);
    out_max       = run_max;
    out_idx       = run_idx;
    out_unordered = nan_seen;
  end

endmodule

// File: tb/tb_fcmp_max_reducer.sv
// Directed bench for fcmp_max_reducer: table of 4-element streams plus backpressure,
// input-gap and mid-stream reset sequences. Expectations follow FCMP_MAX_NAN_PROPAGATE_EN.
module tb_fcmp_max_reducer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_max;
  logic [1:0]  out_idx;
  logic        out_unordered;

  int passed;
  int total;

  fcmp_max_reducer #(.N_ELEMS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_max       (out_max),
    .out_idx       (out_idx),
    .out_unordered (out_unordered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][10:0] d;
    logic [10:0]      emax;
    logic [1:0]       eidx;
    logic             eun;
    string            name;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [10:0] a, input logic [10:0] b,
                              input logic [10:0] c, input logic [10:0] e,
                              input logic [10:0] m, input logic [1:0] i, input logic u);
    vec_t v;
    v.name = n;
    v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
    v.emax = m; v.eidx = i; v.eun = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Offer one element after `gap` idle cycles; returns just after the accepting edge.
  task automatic send(input logic [10:0] x, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 11'h7FF;
  endtask

  // Full reduction: checks valid timing, result fields and release; `hold` cycles of backpressure.
  task automatic run_stream(input vec_t v, input int gap, input int hold);
    for (int k = 0; k < 4; k++) begin
      send(v.d[k], gap);
      if (k == 2) chk({v.name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk({v.name, "_valid"}, 32'(out_valid), 32'd1);
    chk({v.name, "_max"},   32'(out_max), 32'(v.emax));
    chk({v.name, "_idx"},   32'(out_idx), 32'(v.eidx));
    chk({v.name, "_unord"}, 32'(out_unordered), 32'(v.eun));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 11'h400;
      @(negedge clk);
      chk({v.name, "_hold_stable"},
          32'({out_valid, in_ready, out_max, out_idx, out_unordered}),
          32'({1'b1, 1'b0, v.emax, v.eidx, v.eun}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({v.name, "_released"}, 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = mk("basic",    11'h270, 11'h280, 11'h370, 11'h000, 11'h280, 2'd1, 1'b0);
    vecs[1] = mk("infs",     11'h500, 11'h370, 11'h400, 11'h280, 11'h400, 2'd2, 1'b0);
    vecs[2] = mk("ties",     11'h270, 11'h270, 11'h270, 11'h270, 11'h270, 2'd0, 1'b0);
`ifdef FCMP_MAX_NAN_PROPAGATE_EN
    vecs[3] = mk("nan_mid",  11'h270, 11'h600, 11'h280, 11'h370, 11'h600, 2'd1, 1'b1);
    vecs[6] = mk("nan_head", 11'h600, 11'h370, 11'h280, 11'h270, 11'h600, 2'd0, 1'b1);
`else
    vecs[3] = mk("nan_mid",  11'h270, 11'h600, 11'h280, 11'h370, 11'h280, 2'd2, 1'b1);
    vecs[6] = mk("nan_head", 11'h600, 11'h370, 11'h280, 11'h270, 11'h280, 2'd2, 1'b1);
`endif
    vecs[4] = mk("all_nan",  11'h600, 11'h600, 11'h600, 11'h600, 11'h600, 2'd0, 1'b1);
    vecs[5] = mk("zeros",    11'h000, 11'h100, 11'h370, 11'h500, 11'h000, 2'd0, 1'b0);
    vecs[7] = mk("last_max", 11'h370, 11'h000, 11'h270, 11'h280, 11'h280, 2'd3, 1'b0);

    // Reset values while reset is asserted.
    #12;
    chk("reset_outputs",
        32'({out_valid, in_ready, out_max, out_idx, out_unordered}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_stream(vecs[i], 0, 0);

    // Backpressure for 5 cycles with in_valid pressing, then input gaps between elements.
    run_stream(vecs[0], 0, 5);
    run_stream(vecs[1], 3, 0);

    // Asynchronous reset after two accepts discards the partial reduction.
    send(11'h400, 0);
    send(11'h270, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        32'({out_valid, in_ready, out_max, out_idx, out_unordered}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = mk("after_reset", 11'h370, 11'h270, 11'h000, 11'h280, 11'h280, 2'd3, 1'b0);
    run_stream(v, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
